// File: rtl/sprite_pkg.sv
// Shared constants, widths and scheduler state type for the sprite frame scheduler.
package sprite_pkg;

    localparam int unsigned N_SPR      = 4;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned PER_W      = 6;
    localparam int unsigned ROW_W      = 10;
    localparam int unsigned VBLANK_ROW = 493;

    // 640x480 @ 60 Hz timing, kept here so the sync generator and scheduler agree
    localparam int unsigned H_ACTIVE   = 640;
    localparam int unsigned H_TOTAL    = 800;
    localparam int unsigned V_ACTIVE   = 480;
    localparam int unsigned V_TOTAL    = 525;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_t;

endpackage

// File: rtl/sprite_frame_sched_if.sv
// Update handshake between the frame scheduler (master) and the sprite engine (slave).
interface sprite_frame_sched_if;
    import sprite_pkg::*;

    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_ready;

    modport master (output upd_valid, output upd_idx, input upd_ready);
    modport slave  (input upd_valid, input upd_idx, output upd_ready);

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or above ptr, wrapping.
module rr_pick
    import sprite_pkg::*;
(
    input  logic [N_SPR-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr is the one kept
    always_comb begin
        found = |req;
        idx   = '0;
        cand  = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/sprite_frame_sched.sv
// Per-sprite animation scheduler: one tick per frame at vblank entry, per-sprite
// frame dividers, and round-robin serving of due sprites on one update port.
// Build option: define SPR_VBLANK_GATE_EN to start new offers only during vblank.
module sprite_frame_sched
    import sprite_pkg::*;
(
    input  logic               clk_25,
    input  logic               rst_n,
    input  logic [ROW_W-1:0]   row,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [PER_W-1:0]   cfg_period,
    input  logic               cfg_en,
    input  logic               ovr_clr,
    sprite_frame_sched_if.master upd,
    output logic               frame_tick,
    output logic               busy,
    output logic               overrun
);

    sched_state_t     state;
    logic             in_vb;
    logic             in_vb_q;
    logic [PER_W-1:0] cnt     [N_SPR];
    logic [PER_W-1:0] period  [N_SPR];
    logic [PER_W-1:0] cnt_d   [N_SPR];
    logic [N_SPR-1:0] en;
    logic [N_SPR-1:0] pending;
    logic [N_SPR-1:0] pend_d;
    logic [N_SPR-1:0] acc_vec;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic             found;
    logic             go;
    logic             accept;
    logic             valid_d;
    logic             ovr_set;

    assign in_vb  = (row >= ROW_W'(VBLANK_ROW));
    assign accept = (state == OFFER) && upd.upd_ready;

`ifdef SPR_VBLANK_GATE_EN
    assign go = (state == IDLE) && found && in_vb;
`else
    assign go = (state == IDLE) && found;
`endif

    assign valid_d = go | (upd.upd_valid & ~accept);

    rr_pick u_rr_pick (
        .req   (pending),
        .ptr   (rr_ptr),
        .found (found),
        .idx   (pick)
    );

    // One-hot of the sprite being accepted this cycle
    always_comb begin
        acc_vec = '0;
        if (accept) begin
            acc_vec = N_SPR'(1) << upd.upd_idx;
        end
    end

    // Divider and pending next-state; a config write to a sprite masks its tick
    always_comb begin
        pend_d  = pending & ~acc_vec;
        ovr_set = 1'b0;
        for (int s = 0; s < N_SPR; s++) begin
            cnt_d[s] = cnt[s];
            if (cfg_we && (cfg_idx == IDX_W'(s))) begin
                cnt_d[s] = '0;
            end else if (frame_tick && en[s]) begin
                if (cnt[s] == period[s]) begin
                    cnt_d[s]  = '0;
                    pend_d[s] = 1'b1;
                    if (pending[s] && !acc_vec[s]) begin
                        ovr_set = 1'b1;
                    end
                end else begin
                    cnt_d[s] = cnt[s] + PER_W'(1);
                end
            end
        end
    end

    // Frame tick, divider state, configuration and sticky overrun
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            in_vb_q    <= 1'b1;
            frame_tick <= 1'b0;
            en         <= '0;
            pending    <= '0;
            overrun    <= 1'b0;
            for (int s = 0; s < N_SPR; s++) begin
                cnt[s]    <= '0;
                period[s] <= '0;
            end
        end else begin
            in_vb_q    <= in_vb;
            frame_tick <= in_vb & ~in_vb_q;
            pending    <= pend_d;
            overrun    <= ovr_set | (overrun & ~ovr_clr);
            for (int s = 0; s < N_SPR; s++) begin
                cnt[s] <= cnt_d[s];
            end
            if (cfg_we) begin
                period[cfg_idx] <= cfg_period;
                en[cfg_idx]     <= cfg_en;
            end
        end
    end

    // Scheduler FSM: latch a pending sprite, hold the offer until accepted
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            state         <= IDLE;
            upd.upd_valid <= 1'b0;
            upd.upd_idx   <= '0;
            rr_ptr        <= '0;
            busy          <= 1'b0;
        end else begin
            busy <= (|pend_d) | valid_d;
            case (state)
                IDLE: begin
                    if (go) begin
                        upd.upd_idx   <= pick;
                        upd.upd_valid <= 1'b1;
                        state         <= OFFER;
                    end
                end
                OFFER: begin
                    if (upd.upd_ready) begin
                        upd.upd_valid <= 1'b0;
                        rr_ptr        <= upd.upd_idx + IDX_W'(1);
                        state         <= IDLE;
                    end
                end
                default: begin
                    upd.upd_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_frame_sched.sv
// Scoreboard bench for sprite_frame_sched: directed frames push expected grant
// indices; a negedge monitor pops and compares every accepted update.
module tb_sprite_frame_sched;
    import sprite_pkg::*;

    logic             clk_25 = 1'b0;
    logic             rst_n;
    logic [ROW_W-1:0] row;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [PER_W-1:0] cfg_period;
    logic             cfg_en;
    logic             ovr_clr;
    logic             frame_tick;
    logic             busy;
    logic             overrun;

    sprite_frame_sched_if upd ();

    sprite_frame_sched dut (
        .clk_25     (clk_25),
        .rst_n      (rst_n),
        .row        (row),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .ovr_clr    (ovr_clr),
        .upd        (upd),
        .frame_tick (frame_tick),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #20 clk_25 = ~clk_25;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ticks = 0;
    int cyc = 0;
    int acc_cyc [$];
    int sb [$];
    logic             prev_hold = 1'b0;
    logic [IDX_W-1:0] prev_idx  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk_25) cyc++;

    // Monitor: accepted grants against the scoreboard, offer stability, tick count
    always @(negedge clk_25) begin
        if (frame_tick) n_ticks++;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("offer_held", {31'd0, upd.upd_valid}, 32'd1);
                check("offer_idx_stable", {30'd0, upd.upd_idx}, {30'd0, prev_idx});
            end
            if (upd.upd_valid && upd.upd_ready) begin
                acc_cyc.push_back(cyc);
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL grant: unexpected grant of idx %0d", upd.upd_idx);
                end else begin
                    int e;
                    e = sb.pop_front();
                    if (int'(upd.upd_idx) != e) begin
                        n_bad++;
                        $display("FAIL grant: got idx %0d expected %0d", upd.upd_idx, e);
                    end
                end
            end
            prev_hold = upd.upd_valid && !upd.upd_ready;
            prev_idx  = upd.upd_idx;
        end
    end

    task automatic step();
        @(posedge clk_25);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; row = 10'd500; cfg_we = 1'b0; cfg_idx = '0;
        cfg_period = '0; cfg_en = 1'b0; ovr_clr = 1'b0; upd.upd_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input int idx, input int per, input bit en);
        cfg_we = 1'b1; cfg_idx = IDX_W'(idx); cfg_period = PER_W'(per); cfg_en = en;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic frame();
        row = 10'd0;
        repeat (20) step();
        row = 10'd493;
        repeat (5) step();
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60 && sb.size() != 0; i++) step();
        repeat (4) step();
        check(name, sb.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d grants outstanding", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset mid-blank: outputs clear, no false tick, then one tick per blank entry
        do_reset();
        n_ticks = 0;
        @(negedge clk_25);
        check("rst_upd_valid", {31'd0, upd.upd_valid}, 32'd0);
        check("rst_upd_idx", {30'd0, upd.upd_idx}, 32'd0);
        check("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        repeat (5) step();
        check("no_tick_mid_blank", n_ticks, 32'd0);
        row = 10'd0;
        repeat (3) step();
        row = 10'd493;
        @(negedge clk_25);
        check("tick_not_same_cycle", {31'd0, frame_tick}, 32'd0);
        step();
        @(negedge clk_25);
        check("tick_one_after", {31'd0, frame_tick}, 32'd1);
        step();
        @(negedge clk_25);
        check("tick_one_cycle", {31'd0, frame_tick}, 32'd0);
        repeat (5) step();
        check("one_tick_per_blank", n_ticks, 32'd1);

        // Sprite 0 every frame, sprite 1 every third frame (served first: rr_ptr=1)
        do_reset();
        cfg_write(0, 0, 1'b1);
        cfg_write(1, 2, 1'b1);
        upd.upd_ready = 1'b1;
        n_ticks = 0;
        for (int f = 1; f <= 9; f++) begin
            if (f % 3 == 0) begin
                sb.push_back(1);
                sb.push_back(0);
            end else begin
                sb.push_back(0);
            end
            frame();
        end
        drain("div_drain");
        check("div_tick_count", n_ticks, 32'd9);

        // All four every frame: 0,1,2,3 spaced 2 cycles, restarting at 0
        do_reset();
        for (int s = 0; s < 4; s++) cfg_write(s, 0, 1'b1);
        upd.upd_ready = 1'b1;
        acc_cyc.delete();
        for (int s = 0; s < 4; s++) sb.push_back(s);
        frame();
        drain("rr_drain1");
        check("rr_accepts", acc_cyc.size(), 32'd4);
        for (int i = 0; i < 3; i++)
            check("rr_spacing", acc_cyc[i+1] - acc_cyc[i], 32'd2);
        for (int s = 0; s < 4; s++) sb.push_back(s);
        frame();
        drain("rr_drain2");

        // Stalled engine: offer held, overrun after second tick, clear, single service
        do_reset();
        cfg_write(2, 0, 1'b1);
        frame();
        @(negedge clk_25);
        check("stall_valid1", {31'd0, upd.upd_valid}, 32'd1);
        check("stall_idx1", {30'd0, upd.upd_idx}, 32'd2);
        check("stall_ovr1", {31'd0, overrun}, 32'd0);
        frame();
        @(negedge clk_25);
        check("stall_valid2", {31'd0, upd.upd_valid}, 32'd1);
        check("stall_idx2", {30'd0, upd.upd_idx}, 32'd2);
        check("stall_ovr2", {31'd0, overrun}, 32'd1);
        check("stall_busy", {31'd0, busy}, 32'd1);
        step();
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        @(negedge clk_25);
        check("ovr_cleared", {31'd0, overrun}, 32'd0);
        step();
        sb.push_back(2);
        upd.upd_ready = 1'b1;
        drain("stall_drain");
        @(negedge clk_25);
        check("stall_idle_valid", {31'd0, upd.upd_valid}, 32'd0);
        check("stall_idle_busy", {31'd0, busy}, 32'd0);

        // Config write coinciding with the tick masks that sprite's fire and zeroes cnt
        do_reset();
        cfg_write(1, 0, 1'b1);
        upd.upd_ready = 1'b1;
        sb.push_back(1);
        frame();
        drain("cfg_pre_drain");
        row = 10'd0;
        repeat (20) step();
        row = 10'd493;
        step();
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_period = 6'd5; cfg_en = 1'b1;
        @(negedge clk_25);
        check("cfg_tick_aligned", {31'd0, frame_tick}, 32'd1);
        step();
        cfg_we = 1'b0;
        repeat (4) step();
        @(negedge clk_25);
        check("cfg_no_pending", {31'd0, busy}, 32'd0);
        check("cfg_no_valid", {31'd0, upd.upd_valid}, 32'd0);
        for (int f = 0; f < 5; f++) frame();
        check("cfg_quiet_5", {31'd0, busy}, 32'd0);
        sb.push_back(1);
        frame();
        drain("cfg_sixth_drain");

        // Pending raised then row moves into active video
        do_reset();
        cfg_write(3, 0, 1'b1);
        row = 10'd0;
        repeat (20) step();
        row = 10'd493;
        step();
        step();
        row = 10'd100;
        repeat (10) step();
        @(negedge clk_25);
`ifdef SPR_VBLANK_GATE_EN
        check("gate_active_video", {31'd0, upd.upd_valid}, 32'd0);
`else
        check("gate_active_video", {31'd0, upd.upd_valid}, 32'd1);
`endif
        check("gate_busy", {31'd0, busy}, 32'd1);
        step();
        cfg_write(3, 0, 1'b0);
        sb.push_back(3);
        upd.upd_ready = 1'b1;
`ifdef SPR_VBLANK_GATE_EN
        repeat (5) step();
        @(negedge clk_25);
        check("gate_still_blocked", {31'd0, upd.upd_valid}, 32'd0);
        step();
        row = 10'd493;
`endif
        drain("gate_drain");
        @(negedge clk_25);
        check("gate_end_busy", {31'd0, busy}, 32'd0);
        check("gate_end_ovr", {31'd0, overrun}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
